// File: rtl/patternbuf_pkg.sv
// rtl/patternbuf_pkg.sv - shared constants and sizing helpers for the banked pattern buffer
// Purpose: default geometry of the pattern store plus width helpers used by
//          patternbuf_bank and patternbuf_banked.
// Contents: DEF_BUF_WIDTH, DEF_BUF_SIZE, DEF_NUM_BANKS, addr_w(), cnt_w().
package patternbuf_pkg;

  localparam int DEF_BUF_WIDTH = 8;
  localparam int DEF_BUF_SIZE  = 32;
  localparam int DEF_NUM_BANKS = 2;

  // Index width for 'size' entries; never narrower than one bit.
  function automatic int addr_w(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

  // Serial bit counter width: must be able to hold size*width itself.
  function automatic int cnt_w(input int size, input int width);
    return $clog2(size * width + 1);
  endfunction

endpackage

// File: rtl/patternbuf_bank.sv
// rtl/patternbuf_bank.sv - one pattern bank: serial shift chain plus field write port
// Purpose: BUF_SIZE x BUF_WIDTH register bank. Shift has priority over write.
//          Optional per-field even parity when PATTERNBUF_PARITY_EN is defined.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   shift_en, sin       shift whole bank by one bit, sin enters field 0 bit 0
//   sout                MSB of the last field
//   wr_en, wr_addr,     field write
//   wr_data
//   flat                bank contents, field n at [n*BUF_WIDTH +: BUF_WIDTH]
//   par_recalc, par     (PATTERNBUF_PARITY_EN only) recompute all parity on a
//                       shift, per-field parity bits
module patternbuf_bank
  import patternbuf_pkg::*;
#(
  parameter int BUF_WIDTH = DEF_BUF_WIDTH,
  parameter int BUF_SIZE  = DEF_BUF_SIZE,
  parameter int ADDR_W    = addr_w(DEF_BUF_SIZE)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          shift_en,
  input  logic                          sin,
  output logic                          sout,
  input  logic                          wr_en,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [BUF_WIDTH-1:0]          wr_data,
  output logic [BUF_SIZE*BUF_WIDTH-1:0] flat
`ifdef PATTERNBUF_PARITY_EN
  ,
  input  logic                          par_recalc,
  output logic [BUF_SIZE-1:0]           par
`endif
);

  logic [BUF_WIDTH-1:0] r_mem   [BUF_SIZE];
  logic [BUF_WIDTH-1:0] w_shift [BUF_SIZE];

  // Whole bank as one chain: each field's MSB carries into the next field's LSB.
  always_comb begin
    w_shift[0] = {r_mem[0][BUF_WIDTH-2:0], sin};
    for (int n = 1; n < BUF_SIZE; n++) begin
      w_shift[n] = {r_mem[n][BUF_WIDTH-2:0], r_mem[n-1][BUF_WIDTH-1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < BUF_SIZE; n++) r_mem[n] <= '0;
    end else if (shift_en) begin
      r_mem <= w_shift;
    end else if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

`ifdef PATTERNBUF_PARITY_EN
  logic [BUF_SIZE-1:0] r_par;

  // Parity of the completed load is taken from the post-shift data so it
  // lands on the same edge as the final bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_par <= '0;
    end else if (shift_en) begin
      if (par_recalc) begin
        for (int n = 0; n < BUF_SIZE; n++) r_par[n] <= ^w_shift[n];
      end
    end else if (wr_en) begin
      r_par[wr_addr] <= ^wr_data;
    end
  end

  assign par = r_par;
`endif

  assign sout = r_mem[BUF_SIZE-1][BUF_WIDTH-1];

  for (genvar g = 0; g < BUF_SIZE; g++) begin : g_flat
    assign flat[g*BUF_WIDTH +: BUF_WIDTH] = r_mem[g];
  end

endmodule

// File: rtl/patternbuf_banked.sv
// rtl/patternbuf_banked.sv - multi-bank pattern store with serial shadow load and atomic swap
// Purpose: active bank serves field reads/writes while the shadow bank
//          ((active+1) mod NUM_BANKS) loads serially; swap_req exchanges them.
//          Optional parity: define PATTERNBUF_PARITY_EN to add parity_err.
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   ssel, sin, sout              serial load of shadow bank, shadow chain MSB
//   load_done, shadow_valid      load completion pulse, complete unswapped shadow
//   swap_req, swap_ack           swap request, 1-cycle acknowledge
//   active_bank                  current active bank index
//   field_addr, field_write,     field access on the active bank
//   field_in, field_rd
//   field_byte, field_valid      registered read data and its strobe
//   addr_err                     out-of-range access pulse
//   pattern_flat                 active bank contents
//   parity_err                   (PATTERNBUF_PARITY_EN only) read parity mismatch
module patternbuf_banked
  import patternbuf_pkg::*;
#(
  parameter  int BUF_WIDTH = DEF_BUF_WIDTH,
  parameter  int BUF_SIZE  = DEF_BUF_SIZE,
  parameter  int NUM_BANKS = DEF_NUM_BANKS,
  localparam int ADDR_W    = addr_w(BUF_SIZE),
  localparam int BANK_W    = addr_w(NUM_BANKS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ssel,
  input  logic                          sin,
  output logic                          sout,
  output logic                          load_done,
  output logic                          shadow_valid,
  input  logic                          swap_req,
  output logic                          swap_ack,
  output logic [BANK_W-1:0]             active_bank,
  input  logic [ADDR_W-1:0]             field_addr,
  input  logic                          field_write,
  input  logic [BUF_WIDTH-1:0]          field_in,
  input  logic                          field_rd,
  output logic [BUF_WIDTH-1:0]          field_byte,
  output logic                          field_valid,
  output logic                          addr_err,
`ifdef PATTERNBUF_PARITY_EN
  output logic                          parity_err,
`endif
  output logic [BUF_SIZE*BUF_WIDTH-1:0] pattern_flat
);

  localparam int TOTAL = BUF_SIZE * BUF_WIDTH;
  localparam int CNT_W = cnt_w(BUF_SIZE, BUF_WIDTH);

  logic [CNT_W-1:0]     r_cnt;
  logic [BANK_W-1:0]    r_active;
  logic                 r_shadow_valid;
  logic                 r_load_done;
  logic                 r_swap_ack;
  logic [BUF_WIDTH-1:0] r_field_byte;
  logic                 r_field_valid;
  logic                 r_addr_err;

  logic [BANK_W-1:0]    w_shadow;
  logic                 w_in_range;
  logic                 w_last_bit;
  logic                 w_load_fin;
  logic                 w_swap;
  logic [TOTAL-1:0]     w_flat   [NUM_BANKS];
  logic                 w_sout   [NUM_BANKS];
  logic [BUF_WIDTH-1:0] w_fields [BUF_SIZE];
  logic [BUF_WIDTH-1:0] w_rd_data;

  always_comb begin
    w_shadow = (r_active == BANK_W'(NUM_BANKS - 1)) ? '0 : r_active + BANK_W'(1);
  end

  assign w_in_range = ({1'b0, field_addr} < (ADDR_W + 1)'(BUF_SIZE));
  assign w_last_bit = (r_cnt == CNT_W'(TOTAL - 1));
  // A shift into an already-valid shadow restarts the load, so it never completes one.
  assign w_load_fin = ssel & ~r_shadow_valid & w_last_bit;
  assign w_swap     = swap_req & r_shadow_valid & ~ssel;

`ifdef PATTERNBUF_PARITY_EN
  logic [BUF_SIZE-1:0] w_par [NUM_BANKS];
  logic                r_parity_err;
`endif

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    patternbuf_bank #(
      .BUF_WIDTH (BUF_WIDTH),
      .BUF_SIZE  (BUF_SIZE),
      .ADDR_W    (ADDR_W)
    ) u_bank (
      .clk        (clk),
      .reset      (reset),
      .shift_en   (ssel && (w_shadow == BANK_W'(g))),
      .sin        (sin),
      .sout       (w_sout[g]),
      .wr_en      (field_write && w_in_range && (r_active == BANK_W'(g))),
      .wr_addr    (field_addr),
      .wr_data    (field_in),
      .flat       (w_flat[g])
`ifdef PATTERNBUF_PARITY_EN
      ,
      .par_recalc (w_load_fin),
      .par        (w_par[g])
`endif
    );
  end

  assign pattern_flat = w_flat[r_active];

  for (genvar g = 0; g < BUF_SIZE; g++) begin : g_fields
    assign w_fields[g] = pattern_flat[g*BUF_WIDTH +: BUF_WIDTH];
  end

  assign w_rd_data = w_fields[field_addr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt          <= '0;
      r_active       <= '0;
      r_shadow_valid <= 1'b0;
      r_load_done    <= 1'b0;
      r_swap_ack     <= 1'b0;
      r_field_byte   <= '0;
      r_field_valid  <= 1'b0;
      r_addr_err     <= 1'b0;
    end else begin
      r_load_done <= 1'b0;
      r_swap_ack  <= 1'b0;
      if (ssel) begin
        if (r_shadow_valid) begin
          r_shadow_valid <= 1'b0;
          r_cnt          <= CNT_W'(1);
        end else if (w_last_bit) begin
          r_shadow_valid <= 1'b1;
          r_load_done    <= 1'b1;
          r_cnt          <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else if (w_swap) begin
        r_active       <= w_shadow;
        r_shadow_valid <= 1'b0;
        r_swap_ack     <= 1'b1;
        r_cnt          <= '0;
      end
      // Reads sample the pre-edge active bank: read-before-write and pre-swap data.
      r_field_valid <= field_rd;
      if (field_rd) begin
        r_field_byte <= w_in_range ? w_rd_data : '0;
      end
      r_addr_err <= (field_rd | field_write) & ~w_in_range;
    end
  end

`ifdef PATTERNBUF_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= field_rd & w_in_range & (w_par[r_active][field_addr] != ^w_rd_data);
    end
  end

  assign parity_err = r_parity_err;
`endif

  assign sout         = w_sout[w_shadow];
  assign load_done    = r_load_done;
  assign shadow_valid = r_shadow_valid;
  assign swap_ack     = r_swap_ack;
  assign active_bank  = r_active;
  assign field_byte   = r_field_byte;
  assign field_valid  = r_field_valid;
  assign addr_err     = r_addr_err;

endmodule

// File: tb/tb_patternbuf_banked.sv
// tb/tb_patternbuf_banked.sv - directed self-checking bench for patternbuf_banked
module tb_patternbuf_banked;

  logic         clk = 1'b0;
  logic         reset;
  logic         ssel, sin, swap_req, field_write, field_rd;
  logic [4:0]   field_addr;
  logic [7:0]   field_in;
  logic         sout, load_done, shadow_valid, swap_ack, field_valid, addr_err;
  logic [0:0]   active_bank;
  logic [7:0]   field_byte;
  logic [255:0] pattern_flat;

  logic         s_field_write, s_field_rd;
  logic [4:0]   s_field_addr;
  logic [7:0]   s_field_in;
  logic         s_sout, s_load_done, s_shadow_valid, s_swap_ack, s_field_valid, s_addr_err;
  logic [0:0]   s_active_bank;
  logic [7:0]   s_field_byte;
  logic [159:0] s_pattern_flat;

`ifdef PATTERNBUF_PARITY_EN
  logic parity_err, s_parity_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [255:0] p1, p2, q, r, flat0;

  always #5 clk = ~clk;

  patternbuf_banked dut (
    .clk(clk), .reset(reset), .ssel(ssel), .sin(sin), .sout(sout),
    .load_done(load_done), .shadow_valid(shadow_valid),
    .swap_req(swap_req), .swap_ack(swap_ack), .active_bank(active_bank),
    .field_addr(field_addr), .field_write(field_write), .field_in(field_in),
    .field_rd(field_rd), .field_byte(field_byte), .field_valid(field_valid),
    .addr_err(addr_err),
`ifdef PATTERNBUF_PARITY_EN
    .parity_err(parity_err),
`endif
    .pattern_flat(pattern_flat)
  );

  // Non-power-of-two size so out-of-range addresses are reachable.
  patternbuf_banked #(.BUF_SIZE(20)) dut_s (
    .clk(clk), .reset(reset), .ssel(1'b0), .sin(1'b0), .sout(s_sout),
    .load_done(s_load_done), .shadow_valid(s_shadow_valid),
    .swap_req(1'b0), .swap_ack(s_swap_ack), .active_bank(s_active_bank),
    .field_addr(s_field_addr), .field_write(s_field_write), .field_in(s_field_in),
    .field_rd(s_field_rd), .field_byte(s_field_byte), .field_valid(s_field_valid),
    .addr_err(s_addr_err),
`ifdef PATTERNBUF_PARITY_EN
    .parity_err(s_parity_err),
`endif
    .pattern_flat(s_pattern_flat)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Shifts v[hi] first down to v[lo]; a full 255..0 load leaves the bank equal to v.
  task automatic shift_bits(input logic [255:0] v, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      ssel = 1'b1;
      sin  = v[i];
      tick();
    end
    ssel = 1'b0;
    sin  = 1'b0;
  endtask

  initial begin
    for (int n = 0; n < 32; n++) begin
      p1[n*8 +: 8] = 8'(n + 1);
      p2[n*8 +: 8] = 8'h5A;
      q[n*8 +: 8]  = 8'(8'hC0 + n);
      r[n*8 +: 8]  = 8'(8'hFF - n);
    end
    flat0 = '0;
    flat0[5*8 +: 8] = 8'h3C;

    reset = 1'b1; ssel = 0; sin = 0; swap_req = 0; field_write = 0; field_rd = 0;
    field_addr = 0; field_in = 0;
    s_field_write = 0; s_field_rd = 0; s_field_addr = 0; s_field_in = 0;
    tick(); tick();
    chk("rst_field_valid", field_valid, 0);
    chk("rst_field_byte", field_byte, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_shadow_valid", shadow_valid, 0);
    chk("rst_swap_ack", swap_ack, 0);
    chk("rst_active_bank", active_bank, 0);
    chk("rst_addr_err", addr_err, 0);
    chk("rst_sout", sout, 0);
    chk("rst_pattern_flat", pattern_flat, 0);
    chk("rst_s_pattern_flat", s_pattern_flat, 0);
    reset = 1'b0;

    // 1: every field reads zero after reset
    for (int i = 0; i < 32; i++) begin
      field_rd = 1'b1; field_addr = 5'(i);
      tick();
      chk("t1_valid", field_valid, 1);
      chk("t1_byte", field_byte, 0);
    end
    field_rd = 1'b0;
    tick();
    chk("t1_valid_drop", field_valid, 0);

    // 2: write, read back, read-before-write collision
    field_write = 1'b1; field_addr = 5; field_in = 8'hA5;
    tick();
    field_write = 1'b0; field_rd = 1'b1;
    tick();
    chk("t2_rd_a5", field_byte, 8'hA5);
    field_write = 1'b1; field_in = 8'h3C;
    tick();
    chk("t2_collide_old", field_byte, 8'hA5);
    field_write = 1'b0;
    tick();
    chk("t2_rd_3c", field_byte, 8'h3C);
    field_rd = 1'b0;
    tick();
    chk("t2_valid_drop", field_valid, 0);
    chk("t2_byte_hold", field_byte, 8'h3C);

    // 3: full serial load and swap
    shift_bits(p1, 255, 1);
    chk("t3_no_done_255", load_done, 0);
    chk("t3_no_valid_255", shadow_valid, 0);
    shift_bits(p1, 0, 0);
    chk("t3_done_256", load_done, 1);
    chk("t3_valid_256", shadow_valid, 1);
    chk("t3_sout", sout, 0);
    chk("t3_active_untouched", pattern_flat, flat0);
    tick();
    chk("t3_done_pulse", load_done, 0);
    chk("t3_valid_hold", shadow_valid, 1);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    chk("t3_ack", swap_ack, 1);
    chk("t3_active", active_bank, 1);
    chk("t3_valid_clr", shadow_valid, 0);
    chk("t3_flat", pattern_flat, p1);
    field_rd = 1'b1; field_addr = 7;
    tick();
    field_rd = 1'b0;
    chk("t3_ack_pulse", swap_ack, 0);
    chk("t3_rd7", field_byte, 8'h08);

    // 4: ignored swaps, resumed load, coincident swap with read/write
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    chk("t4_noack_invalid", swap_ack, 0);
    chk("t4_active_invalid", active_bank, 1);
    shift_bits(p2, 255, 0);
    chk("t4_p2_valid", shadow_valid, 1);
    ssel = 1'b1; sin = q[255]; swap_req = 1'b1;
    tick();
    ssel = 1'b0;
    chk("t4_noack_ssel", swap_ack, 0);
    chk("t4_active_ssel", active_bank, 1);
    chk("t4_valid_restart", shadow_valid, 0);
    tick();
    swap_req = 1'b0;
    chk("t4_noack_after", swap_ack, 0);
    shift_bits(q, 254, 1);
    chk("t4_resume_no_done", load_done, 0);
    shift_bits(q, 0, 0);
    chk("t4_resume_done", load_done, 1);
    chk("t4_sout", sout, 1);
    swap_req = 1'b1; field_write = 1'b1; field_rd = 1'b1; field_addr = 3; field_in = 8'h77;
    tick();
    swap_req = 1'b0; field_write = 1'b0;
    chk("t4_swap_ack", swap_ack, 1);
    chk("t4_swap_active", active_bank, 0);
    chk("t4_rd_preswap", field_byte, 8'h04);
    chk("t4_flat_q", pattern_flat, q);
    tick();
    field_rd = 1'b0;
    chk("t4_rd_new_active", field_byte, 8'hC3);
`ifdef PATTERNBUF_PARITY_EN
    chk("t4_parity_ok", parity_err, 0);
    force dut.g_bank[0].u_bank.r_par[3] = 1'b1;
    field_rd = 1'b1;
    tick();
    field_rd = 1'b0;
    release dut.g_bank[0].u_bank.r_par[3];
    chk("t4_parity_err", parity_err, 1);
`endif

    // 5: out-of-range access on the 20-field instance
    s_field_write = 1'b1; s_field_addr = 19; s_field_in = 8'h11;
    tick();
    s_field_write = 1'b0;
    chk("t5_inrange_noerr", s_addr_err, 0);
    s_field_rd = 1'b1;
    tick();
    chk("t5_rd19", s_field_byte, 8'h11);
    s_field_write = 1'b1; s_field_addr = 25; s_field_in = 8'hFF;
    tick();
    s_field_write = 1'b0; s_field_rd = 1'b0;
    chk("t5_err", s_addr_err, 1);
    chk("t5_err_valid", s_field_valid, 1);
    chk("t5_err_byte", s_field_byte, 0);
    chk("t5_no_bank_change", s_pattern_flat, 160'h11 << 152);
    tick();
    chk("t5_err_pulse", s_addr_err, 0);
    s_field_rd = 1'b1; s_field_addr = 20;
    tick();
    s_field_rd = 1'b0;
    chk("t5_err_boundary", s_addr_err, 1);

    // 6: reset mid-load, then a fresh full load
    shift_bits(r, 255, 156);
    ssel = 1'b1; reset = 1'b1;
    tick();
    ssel = 1'b0; reset = 1'b0;
    chk("t6_valid", shadow_valid, 0);
    chk("t6_active", active_bank, 0);
    chk("t6_flat", pattern_flat, 0);
    chk("t6_byte", field_byte, 0);
    shift_bits(r, 255, 1);
    chk("t6_no_done_255", load_done, 0);
    shift_bits(r, 0, 0);
    chk("t6_done_256", load_done, 1);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    chk("t6_ack", swap_ack, 1);
    chk("t6_flat_r", pattern_flat, r);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
